wb_port_arbiter: RTL and testbench

- Schedules the single register-file write port between three writeback sources: ALU result, data-memory load return, and stack pop.
- Arbitrates requests and drives the 2-bit select of the registered writeback mux (00 = data mem, 01 = stack, 11 = ALU).
- Delays write-enable and destination address so they line up with the mux's registered output.
- Sits between the execute/memory/stack units and the register file.

---
 rtl/wb_port_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants one of ALU / load / stack-pop per cycle and
// pipelines mux select, write enable and write address. Optional macro WB_ARB_RR_EN.
module wb_port_arbiter #(
  parameter int RW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          alu_req,
  input  logic [RW-1:0] alu_rd,
  output logic          alu_gnt,
  input  logic          mem_req,
  input  logic [RW-1:0] mem_rd,
  output logic          mem_gnt,
  input  logic          stk_req,
  input  logic [RW-1:0] stk_rd,
  output logic          stk_gnt,
  output logic [1:0]    mux_sel,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [1:0] SEL_MEM = 2'b00;
  localparam logic [1:0] SEL_STK = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b11;

  // Request/grant vectors are ordered {alu, stk, mem}.
  logic [2:0]    req_vec;
  logic [2:0]    gnt_vec;
  logic          waiting;

  logic [1:0]    mux_sel_q, mux_sel_d;
  logic          s1_v_q, s1_v_d;
  logic [RW-1:0] s1_rd_q, s1_rd_d;
  logic          rf_we_q, rf_we_d;
  logic [RW-1:0] rf_waddr_q, rf_waddr_d;
  logic [CW-1:0] stall_q, stall_d;

  assign req_vec = {alu_req, stk_req, mem_req};

`ifdef WB_ARB_RR_EN
  // One-hot record of the last granted source; search starts just after it.
  logic [2:0] last_q, last_d;

  always_comb begin
    gnt_vec = 3'b000;
    if (!hold && !rst) begin
      if (last_q[0]) begin
        if (req_vec[1])      gnt_vec = 3'b010;
        else if (req_vec[2]) gnt_vec = 3'b100;
        else if (req_vec[0]) gnt_vec = 3'b001;
      end else if (last_q[1]) begin
        if (req_vec[2])      gnt_vec = 3'b100;
        else if (req_vec[0]) gnt_vec = 3'b001;
        else if (req_vec[1]) gnt_vec = 3'b010;
      end else begin
        if (req_vec[0])      gnt_vec = 3'b001;
        else if (req_vec[1]) gnt_vec = 3'b010;
        else if (req_vec[2]) gnt_vec = 3'b100;
      end
    end
    last_d = (|gnt_vec) ? gnt_vec : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 3'b100;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    gnt_vec = 3'b000;
    if (!hold && !rst) begin
      if (req_vec[0])      gnt_vec = 3'b001;
      else if (req_vec[1]) gnt_vec = 3'b010;
      else if (req_vec[2]) gnt_vec = 3'b100;
    end
  end
`endif

  assign mem_gnt = gnt_vec[0];
  assign stk_gnt = gnt_vec[1];
  assign alu_gnt = gnt_vec[2];

  assign waiting = |(req_vec & ~gnt_vec);

  always_comb begin
    mux_sel_d = mux_sel_q;
    s1_rd_d   = s1_rd_q;
    if (gnt_vec[0]) begin
      mux_sel_d = SEL_MEM;
      s1_rd_d   = mem_rd;
    end else if (gnt_vec[1]) begin
      mux_sel_d = SEL_STK;
      s1_rd_d   = stk_rd;
    end else if (gnt_vec[2]) begin
      mux_sel_d = SEL_ALU;
      s1_rd_d   = alu_rd;
    end
    s1_v_d     = |gnt_vec;
    rf_we_d    = s1_v_q;
    rf_waddr_d = s1_v_q ? s1_rd_q : rf_waddr_q;
    stall_d    = (waiting && (stall_q != {CW{1'b1}})) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_sel_q  <= SEL_ALU;
      s1_v_q     <= 1'b0;
      s1_rd_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      stall_q    <= '0;
    end else begin
      mux_sel_q  <= mux_sel_d;
      s1_v_q     <= s1_v_d;
      s1_rd_q    <= s1_rd_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      stall_q    <= stall_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; a second instance with
// CW=2 shares the inputs to exercise stall counter saturation.
module tb_wb_port_arbiter;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic          alu_req, mem_req, stk_req;
  logic [RW-1:0] alu_rd, mem_rd, stk_rd;
  logic          alu_gnt, mem_gnt, stk_gnt;
  logic [1:0]    mux_sel;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [7:0]    stall_cnt;

  logic          alu_gnt2, mem_gnt2, stk_gnt2;
  logic [1:0]    mux_sel2;
  logic          rf_we2;
  logic [RW-1:0] rf_waddr2;
  logic [1:0]    stall_cnt2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.RW(RW), .CW(8)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .alu_req(alu_req), .alu_rd(alu_rd), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_rd(mem_rd), .mem_gnt(mem_gnt),
    .stk_req(stk_req), .stk_rd(stk_rd), .stk_gnt(stk_gnt),
    .mux_sel(mux_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .stall_cnt(stall_cnt)
  );

  wb_port_arbiter #(.RW(RW), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .hold(hold),
    .alu_req(alu_req), .alu_rd(alu_rd), .alu_gnt(alu_gnt2),
    .mem_req(mem_req), .mem_rd(mem_rd), .mem_gnt(mem_gnt2),
    .stk_req(stk_req), .stk_rd(stk_rd), .stk_gnt(stk_gnt2),
    .mux_sel(mux_sel2), .rf_we(rf_we2), .rf_waddr(rf_waddr2),
    .stall_cnt(stall_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold = 0; alu_req = 0; mem_req = 0; stk_req = 0;
    alu_rd = '0; mem_rd = '0; stk_rd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    mem_req = 1;
    rst = 1;
    #1;
    tests_run++;
    if ({alu_gnt, stk_gnt, mem_gnt} !== 3'b000)
      $display("FAIL reset_gnt: got %b want 000", {alu_gnt, stk_gnt, mem_gnt});
    else tests_failed += 0;
    if ({alu_gnt, stk_gnt, mem_gnt} !== 3'b000) tests_failed++;
    rst = 0; mem_req = 0;
    tests_run++;
    if (mux_sel !== 2'b11 || rf_we !== 1'b0 || rf_waddr !== 4'd0 || stall_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state: mux_sel=%b rf_we=%b rf_waddr=%0d stall=%0d want 11 0 0 0",
               mux_sel, rf_we, rf_waddr, stall_cnt);
    end
    $display("[TB] reset: mux_sel=%b rf_we=%b stall=%0d", mux_sel, rf_we, stall_cnt);
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_req = 1; alu_rd = 4'd5;
    #1;
    tests_run++;
    if ({alu_gnt, stk_gnt, mem_gnt} !== 3'b100) begin
      tests_failed++;
      $display("FAIL alu_gnt: got %b want 100", {alu_gnt, stk_gnt, mem_gnt});
    end
    tick();
    alu_req = 0;
    tests_run++;
    if (mux_sel !== 2'b11 || rf_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_stage1: mux_sel=%b rf_we=%b want 11 0", mux_sel, rf_we);
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd5) begin
      tests_failed++;
      $display("FAIL alu_write: rf_we=%b rf_waddr=%0d want 1 5", rf_we, rf_waddr);
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b0 || rf_waddr !== 4'd5) begin
      tests_failed++;
      $display("FAIL alu_oneshot: rf_we=%b rf_waddr=%0d want 0 5", rf_we, rf_waddr);
    end
    $display("[TB] single alu: rf_waddr=%0d", rf_waddr);
  endtask

  task automatic test_all_three();
    logic [2:0] exp_gnt [3];
    logic [1:0] exp_sel [3];
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100;
    exp_sel[0] = 2'b00;  exp_sel[1] = 2'b01;  exp_sel[2] = 2'b11;
    do_reset();
    mem_req = 1; mem_rd = 4'd1;
    stk_req = 1; stk_rd = 4'd2;
    alu_req = 1; alu_rd = 4'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if ({alu_gnt, stk_gnt, mem_gnt} !== exp_gnt[c]) begin
        tests_failed++;
        $display("FAIL three_gnt%0d: got %b want %b", c, {alu_gnt, stk_gnt, mem_gnt}, exp_gnt[c]);
      end
      tick();
      if (exp_gnt[c][0]) mem_req = 0;
      if (exp_gnt[c][1]) stk_req = 0;
      if (exp_gnt[c][2]) alu_req = 0;
      tests_run++;
      if (mux_sel !== exp_sel[c]) begin
        tests_failed++;
        $display("FAIL three_sel%0d: got %b want %b", c, mux_sel, exp_sel[c]);
      end
      if (c >= 1) begin
        tests_run++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'(c)) begin
          tests_failed++;
          $display("FAIL three_wr%0d: rf_we=%b rf_waddr=%0d want 1 %0d", c, rf_we, rf_waddr, c);
        end
      end
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd3) begin
      tests_failed++;
      $display("FAIL three_wr3: rf_we=%b rf_waddr=%0d want 1 3", rf_we, rf_waddr);
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL three_drain: rf_we=%b want 0", rf_we);
    end
    // Someone was left waiting on the first two grant edges only.
    tests_run++;
    if (stall_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL three_stall: got %0d want 2", stall_cnt);
    end
    $display("[TB] three requesters: stall=%0d", stall_cnt);
  endtask

  task automatic test_mem_alu_held();
    logic [2:0] exp;
    do_reset();
    mem_req = 1; mem_rd = 4'd7;
    alu_req = 1; alu_rd = 4'd8;
    for (int c = 0; c < 4; c++) begin
      #1;
`ifdef WB_ARB_RR_EN
      exp = (c % 2 == 0) ? 3'b001 : 3'b100;
`else
      exp = 3'b001;
`endif
      tests_run++;
      if ({alu_gnt, stk_gnt, mem_gnt} !== exp) begin
        tests_failed++;
        $display("FAIL held_gnt%0d: got %b want %b", c, {alu_gnt, stk_gnt, mem_gnt}, exp);
      end
      tick();
    end
    tests_run++;
    if (stall_cnt !== 8'd4) begin
      tests_failed++;
      $display("FAIL held_stall: got %0d want 4", stall_cnt);
    end
    idle_inputs();
    $display("[TB] mem+alu held: stall=%0d", stall_cnt);
  endtask

  task automatic test_hold();
    do_reset();
    // A grant issued just before hold still reaches the register file.
    alu_req = 1; alu_rd = 4'd11;
    tick();
    alu_req = 0; hold = 1;
    stk_req = 1; stk_rd = 4'd9;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if ({alu_gnt, stk_gnt, mem_gnt} !== 3'b000) begin
        tests_failed++;
        $display("FAIL hold_gnt%0d: got %b want 000", c, {alu_gnt, stk_gnt, mem_gnt});
      end
      tick();
      tests_run++;
      if (rf_we !== (c == 0) || (c == 0 && rf_waddr !== 4'd11)) begin
        tests_failed++;
        $display("FAIL hold_we%0d: rf_we=%b rf_waddr=%0d want %0d 11", c, rf_we, rf_waddr, c == 0);
      end
    end
    tests_run++;
    if (stall_cnt !== 8'd4) begin
      tests_failed++;
      $display("FAIL hold_stall: got %0d want 4", stall_cnt);
    end
    hold = 0;
    #1;
    tests_run++;
    if ({alu_gnt, stk_gnt, mem_gnt} !== 3'b010) begin
      tests_failed++;
      $display("FAIL hold_release: got %b want 010", {alu_gnt, stk_gnt, mem_gnt});
    end
    tick();
    stk_req = 0;
    tests_run++;
    if (mux_sel !== 2'b01 || stall_cnt !== 8'd4) begin
      tests_failed++;
      $display("FAIL hold_sel: mux_sel=%b stall=%0d want 01 4", mux_sel, stall_cnt);
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b1 || rf_waddr !== 4'd9) begin
      tests_failed++;
      $display("FAIL hold_write: rf_we=%b rf_waddr=%0d want 1 9", rf_we, rf_waddr);
    end
    $display("[TB] hold: stall=%0d rf_waddr=%0d", stall_cnt, rf_waddr);
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req = 1; mem_rd = 4'd4;
    alu_req = 1; alu_rd = 4'd6;
    tick();
    mem_req = 0;
    tests_run++;
    if (mux_sel !== 2'b00 || stall_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL mid_pre: mux_sel=%b stall=%0d want 00 1", mux_sel, stall_cnt);
    end
    rst = 1;
    tick();
    rst = 0; alu_req = 0;
    tests_run++;
    if (rf_we !== 1'b0 || mux_sel !== 2'b11 || stall_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_rst: rf_we=%b mux_sel=%b stall=%0d want 0 11 0", rf_we, mux_sel, stall_cnt);
    end
    tick();
    tests_run++;
    if (rf_we !== 1'b0 || rf_waddr !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_after: rf_we=%b rf_waddr=%0d want 0 0", rf_we, rf_waddr);
    end
    $display("[TB] reset mid-op: rf_we=%b mux_sel=%b", rf_we, mux_sel);
  endtask

  task automatic test_saturate();
    do_reset();
    hold = 1; stk_req = 1; stk_rd = 4'd2;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 2) begin
        tests_run++;
        if (stall_cnt2 !== 2'd3) begin
          tests_failed++;
          $display("FAIL sat_reach: got %0d want 3", stall_cnt2);
        end
      end
    end
    tests_run++;
    if (stall_cnt2 !== 2'd3 || stall_cnt !== 8'd6) begin
      tests_failed++;
      $display("FAIL sat_hold: cw2=%0d cw8=%0d want 3 6", stall_cnt2, stall_cnt);
    end
    idle_inputs();
    $display("[TB] saturate: cw2=%0d cw8=%0d", stall_cnt2, stall_cnt);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_alu();
    test_all_three();
    test_mem_alu_held();
    test_hold();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
